// File: rtl/axi4_read_master_pkg.sv
// Shared types and AXI constants for the single-ID AXI4 read master.
// The FSM encoding is also driven out on the debug port.
package axi4_read_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // Full-width beats: ARSIZE is log2 of the bus width in bytes.
   function automatic logic [2:0] calc_arsize(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/axi4_read_master.sv
// Issues one INCR AR burst per granted command and returns its R beats.
// Only one burst is ever outstanding; beat count alone decides burst end.
module axi4_read_master
   import axi4_read_master_pkg::*;
#(
   parameter int                      AXI_ADDR_WIDTH = 32,
   parameter int                      AXI_DATA_WIDTH = 64,
   parameter int                      AXI_ID_WIDTH   = 4,
   parameter logic [AXI_ID_WIDTH-1:0] AXI_ID_VALUE   = '0
) (
   input  logic                      sys_clk_i,
   input  logic                      reset_i,
   input  logic                      req_i,
   input  logic [AXI_ADDR_WIDTH-1:0] rstart_addr_i,
   input  logic [7:0]                burst_size_i,
   output logic                      ack_o,
   output logic                      data_valid_o,
   output logic [AXI_DATA_WIDTH-1:0] rdata_o,
   output logic                      done_o,
   output logic                      rresp_err_o,
   output logic                      len_err_o,
   output logic [AXI_ID_WIDTH-1:0]   arid_o,
   output logic [AXI_ADDR_WIDTH-1:0] araddr_o,
   output logic [7:0]                arlen_o,
   output logic [2:0]                arsize_o,
   output logic [1:0]                arburst_o,
   output logic                      arvalid_o,
   input  logic                      arready_i,
   input  logic [AXI_ID_WIDTH-1:0]   rid_i,
   input  logic [AXI_DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]                rresp_i,
   input  logic                      rlast_i,
   input  logic                      rvalid_i,
   output logic                      rready_o,
   output logic [1:0]                dbg_state_o
);

   // Handshakes: AR transfers when arvalid_o & arready_i at a rising edge,
   // R transfers when rvalid_i & rready_o; req_i is a level held until ack_o.

   state_e                      state_q, state_d;
   logic                        ack_q, ack_d;
   logic                        dv_q, dv_d;
   logic                        done_q, done_d;
   logic                        rresp_err_q, rresp_err_d;
   logic                        len_err_q, len_err_d;
   logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [7:0]                  arlen_q, arlen_d;
   logic [7:0]                  cnt_q, cnt_d;

   logic accept, beat, final_beat;
   logic unused_rid;

   assign unused_rid = ^rid_i;

   // The done_q guard keeps a stale req from being taken the cycle the
   // scheduler is still moving its select after the previous burst.
   assign accept     = (state_q == ST_IDLE) && req_i && !done_q;
   assign beat       = (state_q == ST_DATA) && rvalid_i;
   assign final_beat = beat && (cnt_q == arlen_q);

   always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)     state_d = ST_ADDR;
         ST_ADDR: if (arready_i)  state_d = ST_DATA;
         ST_DATA: if (final_beat) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ack_d       = accept;
      dv_d        = beat;
      done_d      = final_beat;
      rdata_d     = rdata_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      cnt_d       = cnt_q;
      rresp_err_d = rresp_err_q;
      len_err_d   = len_err_q;
      if (accept) begin
         araddr_d    = rstart_addr_i;
         arlen_d     = burst_size_i;
         cnt_d       = 8'd0;
         rresp_err_d = 1'b0;
         len_err_d   = 1'b0;
      end
      if (beat) begin
         rdata_d = rdata_i;
         if (!final_beat) cnt_d = cnt_q + 8'd1;
         if (rresp_i != RESP_OKAY) rresp_err_d = 1'b1;
         if (rlast_i != final_beat) len_err_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) begin
         ack_q       <= 1'b0;
         dv_q        <= 1'b0;
         done_q      <= 1'b0;
         rdata_q     <= '0;
         araddr_q    <= '0;
         arlen_q     <= 8'd0;
         cnt_q       <= 8'd0;
         rresp_err_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         ack_q       <= ack_d;
         dv_q        <= dv_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         cnt_q       <= cnt_d;
         rresp_err_q <= rresp_err_d;
         len_err_q   <= len_err_d;
      end
   end

   assign ack_o        = ack_q;
   assign data_valid_o = dv_q;
   assign done_o       = done_q;
   assign rdata_o      = rdata_q;
   assign rresp_err_o  = rresp_err_q;
   assign len_err_o    = len_err_q;
   assign araddr_o     = araddr_q;
   assign arlen_o      = arlen_q;
   assign arid_o       = AXI_ID_VALUE;
   assign arsize_o     = calc_arsize(AXI_DATA_WIDTH);
   assign arburst_o    = BURST_INCR;
   assign arvalid_o    = (state_q == ST_ADDR);
   assign rready_o     = (state_q == ST_DATA);
   assign dbg_state_o  = state_q;

endmodule

// File: doc/axi4_read_master.md
Name: axi4_read_master

Overview:
- Downstream stage of the DDR AXI4 arbiter read path.
- Accepts one granted read command (req/start address/burst size) from the arbitrated read channel and issues a single AXI4 AR transaction.
- Collects the R beats and returns per-beat data_valid, an ack on command acceptance and a done pulse at burst end, to the request scheduler and demux.
- One outstanding burst at a time; fixed ID, INCR bursts, full-width beats.

Parameters:
- AXI_ADDR_WIDTH, 32, width of start address and ARADDR
- AXI_DATA_WIDTH, 64, width of RDATA and rdata_o; power of two, 32..512
- AXI_ID_WIDTH, 4, width of ARID/RID
- AXI_ID_VALUE, 0, constant ARID driven on every transaction

Ports:
- sys_clk_i  in  1  system clock, all logic rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_i  in  1  read command request from arbiter, level, held until ack_o
- rstart_addr_i  in  AXI_ADDR_WIDTH  burst start byte address
- burst_size_i  in  8  AXI ARLEN encoding (beats = burst_size_i+1)
- ack_o  out  1  one-cycle pulse: command accepted and latched
- data_valid_o  out  1  one-cycle pulse per returned beat, qualifies rdata_o
- rdata_o  out  AXI_DATA_WIDTH  registered read beat
- done_o  out  1  one-cycle pulse coincident with the final data_valid_o
- rresp_err_o  out  1  sticky: any beat of current burst had RRESP!=OKAY; cleared on ack_o
- len_err_o  out  1  sticky: RLAST position disagreed with burst_size; cleared on ack_o
- arid_o  out  AXI_ID_WIDTH  = AXI_ID_VALUE
- araddr_o  out  AXI_ADDR_WIDTH  latched start address
- arlen_o  out  8  latched burst_size
- arsize_o  out  3  constant log2(AXI_DATA_WIDTH/8)
- arburst_o  out  2  constant 2'b01 (INCR)
- arvalid_o  out  1  AR valid
- arready_i  in  1  AR ready
- rid_i  in  AXI_ID_WIDTH  ignored (single ID)
- rdata_i  in  AXI_DATA_WIDTH  R data
- rresp_i  in  2  R response
- rlast_i  in  1  R last
- rvalid_i  in  1  R valid
- rready_o  out  1  R ready

Behaviour:
- Reset (async, reset_i=1): state IDLE; ack_o, data_valid_o, done_o, arvalid_o, rready_o, rresp_err_o, len_err_o = 0; rdata_o, araddr_o, arlen_o, beat counter = 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE: if req_i=1 and done_o=0 this cycle, then next cycle: ack_o=1 (single cycle), araddr_o/arlen_o latched from inputs, arvalid_o=1, error flags cleared, counter=0, state ADDR. The done_o guard enforces at least 2 cycles from done_o to the next ack_o, so a stale req is never taken while the scheduler updates its mux select.
- ADDR: arvalid_o held with stable araddr/arlen until arready_i=1. On handshake cycle: next cycle arvalid_o=0, rready_o=1, state DATA. arready_i high on the first arvalid cycle gives a 1-cycle ADDR dwell.
- DATA: rready_o=1 continuously. Each rvalid_i&rready_o beat registers rdata_o and pulses data_valid_o next cycle (latency 1). Counter increments per beat (8-bit, no wrap beyond arlen).
  - rresp_i!=2'b00 on any beat sets rresp_err_o.
  - Burst ends on the beat where counter==arlen_o. That beat's data_valid_o and done_o assert together; rready_o drops and state returns to IDLE in the same cycle.
  - rlast_i=1 on a non-final beat, or rlast_i=0 on the final beat, sets len_err_o; termination is still decided by the counter only.
- req_i and command inputs are ignored outside IDLE.
- Reset mid-burst: immediate return to IDLE, all outputs to reset values; outstanding R beats after reset are the interconnect's concern (rready_o=0).
- burst_size_i=0 gives a single beat; done_o coincides with the first data_valid_o.
- 4 KB boundary crossing is the requestor's responsibility; not checked.

Decomposition:
- Shared package: FSM state encoding (IDLE/ADDR/DATA), AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00), arsize function of data width.
- No sub-module needed; a single FSM plus datapath registers.

Test Plan:
- Basic burst: req_i=1, addr=0x0000_1000, size=3, arready same cycle, 4 back-to-back beats with rlast on 4th -> ack_o 1 cycle, araddr_o=0x1000, arlen_o=3, four data_valid_o, done_o with the 4th, no error flags.
- Single beat with backpressure: size=0, arready delayed 5 cycles, rvalid gaps of 2 cycles -> arvalid_o stable 6 cycles, exactly one data_valid_o carrying done_o.
- Error response: size=7, beat 3 has rresp=2'b10 -> rresp_err_o=1 from beat 3 until the next ack_o; 8 data_valid_o, done_o on 8th.
- RLAST mismatch: size=3, rlast on beat 2 -> len_err_o=1, done_o still on 4th beat.
- Back-to-back: req_i held high across done_o -> next ack_o no earlier than 2 cycles after done_o; second address and size latched correctly.
- Reset mid-burst: reset_i pulsed after beat 2 of 8 -> all outputs 0 asynchronously, FSM in IDLE, next request completes normally.
